gfsk_tx_sequencer: RTL and testbench
====================================

# gfsk_tx_sequencer

Packet-level transmit controller for the GFSK modulator path. On a start request it serializes a BLE-style packet: 8-bit preamble, 32-bit access address, then N payload bytes pulled over a valid/ready byte stream. It runs the bits through a 3-tap Gaussian-approximating shaper and drives the 3-bit frequency code (`gfsk_out`) consumed by the RF frontend. It sits between the core's MMIO/DMA byte source and the modulator output pins, and owns symbol timing.

## Interface
- `SYMBOL_CYCLES`, 10, clock cycles per symbol (1 Msym/s at a 10 MHz `clock`); must be ≥1.
- `PREAMBLE`, 8'hAA, preamble byte, sent LSB first.
- `ACCESS_ADDR`, 32'h8E89BED6, access address, sent LSB first.

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request; honoured only in IDLE.
- `len`  in  8  payload byte count, sampled with `start`; 0 is legal.
- `in_data`  in  8  payload byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  byte buffer empty and more bytes needed.
- `busy`  out  1  packet in progress.
- `done`  out  1  one-cycle pulse at packet end.
- `underrun`  out  1  sticky; a payload byte was needed but unavailable.
- `bit_out`  out  1  current serialized bit (unshaped, debug).
- `gfsk_out`  out  3  shaped frequency code, 0..7.

## Operation
- States: IDLE → PREAMBLE (8 sym) → ACCESS (32 sym) → PAYLOAD (8·len sym) → TAIL (2 sym) → IDLE. If len=0, ACCESS goes directly to TAIL.
- IDLE + `start`: latch `len`, clear `underrun`, clear shaper window and byte buffer, then enter PREAMBLE. `start` in any other state is ignored.
- The symbol counter counts 0..SYMBOL_CYCLES-1. A bit boundary occurs at wrap. A bit index counts within each field. Each field is shifted LSB first.
- Byte buffer, one entry: `in_ready` = buffer empty && state ∈ {ACCESS, PAYLOAD} && bytes_fetched < len. The transfer happens when `in_valid && in_ready`.
- At each payload byte boundary, the shift register loads from the buffer and marks it empty. If the buffer is empty at that boundary, load 8'h00 and set `underrun`; the byte count still advances.
- TAIL shifts in zero bits to flush the shaper lookahead.
- Shaper: window {prev, cur, next}. On each bit boundary, shift in the new serializer bit as `next`. Output `gfsk_out` = 2·prev + 3·cur + 2·next (max 7, no overflow). As a result, `gfsk_out` lags `bit_out` by exactly one symbol.
- Reset, or reaching IDLE: all outputs 0. `gfsk_out` = 0 because the window is all zeros.
- Reset mid-packet aborts immediately. There is no `done` pulse, and the next packet needs a new `start`.

## Timing
- `start` sampled high at cycle t: `busy` = 1 from t+1. Preamble bit 0 appears on `bit_out` from t+1. Its shaped code appears on `gfsk_out` from t+1+SYMBOL_CYCLES.
- `gfsk_out` and `bit_out` are registered and change only on symbol boundaries.
- Packet duration: (8+32+8·len+2)·SYMBOL_CYCLES cycles of `busy`.
- `done` pulses in the first cycle `busy` is low. `start` is accepted again in that same cycle.
- Byte-fetch deadline: a byte must transfer before the payload boundary that consumes it. The first byte can transfer as early as ACCESS state.

## Structure
- Package `gfsk_pkg`: state enum, default `PREAMBLE`/`ACCESS_ADDR` constants, shaper weights (2,3,2), TAIL length.
- Sub-module `gfsk_shaper`: 3-bit window, weighted sum, registered code output, synchronous clear.
- Top level: FSM, symbol counter, bit/byte counters, shift register, byte buffer.

## Test plan
- len=0, SYMBOL_CYCLES=10, start at t: `busy` high for 420 cycles, `done` pulse at t+421. The first `gfsk_out` codes are 2,3,4,3,4,3,4,… starting at t+11.
- len=2, bytes 8'h01 then 8'hFF offered early: serialized payload bits are 1,0,0,0,0,0,0,0,1×8. `underrun`=0. Exactly 2 `in_ready`/`in_valid` transfers.
- len=2, `in_valid` held low: payload is 16 zero bits, `underrun`=1 after the first payload boundary, the packet still completes with `done`. `underrun` clears on the next `start`.
- `start` pulsed mid-PAYLOAD: ignored, and the packet length is unchanged.
- `reset` asserted mid-ACCESS for 1 cycle: next cycle all outputs 0 and the FSM is in IDLE. No `done` pulse. A new `start` produces a full packet.
- SYMBOL_CYCLES=1, len=1, byte 8'hA5: 50 `busy` cycles. `gfsk_out` equals 2·b[k-1]+3·b[k]+2·b[k+1], checked against a reference model every cycle.

Source files
------------

// File: rtl/gfsk_pkg.sv
// -----------------------------------------------------------------------------
// gfsk_pkg
// Shared constants for the GFSK transmit path.
//   - FSM state encodings for the packet sequencer
//   - Default preamble and access address
//   - Shaper tap weights {prev, cur, next} and tail length
// -----------------------------------------------------------------------------
package gfsk_pkg;

    // Sequencer states
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PREAMBLE = 3'd1;
    localparam logic [2:0] ST_ACCESS   = 3'd2;
    localparam logic [2:0] ST_PAYLOAD  = 3'd3;
    localparam logic [2:0] ST_TAIL     = 3'd4;

    localparam logic [7:0]  DEFAULT_PREAMBLE    = 8'hAA;
    localparam logic [31:0] DEFAULT_ACCESS_ADDR = 32'h8E89BED6;

    // Tap weights indexed by window position: [2]=prev, [1]=cur, [0]=next.
    // 2+3+2 = 7 fits the 3-bit code exactly, so the sum never overflows.
    localparam logic [2:0][2:0] SHAPER_WEIGHTS = {3'd2, 3'd3, 3'd2};

    // Zero symbols appended after the last data bit to flush the lookahead
    localparam int unsigned TAIL_BITS = 2;

endpackage

// File: rtl/gfsk_shaper.sv
// -----------------------------------------------------------------------------
// gfsk_shaper
// Three-tap Gaussian-approximating pulse shaper.
//   clock  : clock
//   reset  : synchronous active-high reset (window and code to zero)
//   clear  : restart the window as {0, 0, bit_in}, code forced to 0
//   shift  : shift bit_in into the window as the new 'next' tap
//   bit_in : serializer bit
//   code   : registered frequency code 2*prev + 3*cur + 2*next
// -----------------------------------------------------------------------------
module gfsk_shaper
    import gfsk_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       shift,
    input  logic       bit_in,
    output logic [2:0] code
);

    // window_reg[2] = prev, [1] = cur, [0] = next
    logic [2:0] window_reg;
    logic [2:0] window_next;
    logic [2:0] code_reg;
    logic [2:0] term [3];
    logic [2:0] code_next;

    assign window_next = {window_reg[1:0], bit_in};

    // The code is computed from the post-shift window so that it updates
    // on the same edge the new bit enters, keeping exactly one symbol of lag.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_tap
            assign term[gi] = window_next[gi] ? SHAPER_WEIGHTS[gi] : 3'd0;
        end
    endgenerate

    assign code_next = term[0] + term[1] + term[2];

    always_ff @(posedge clock) begin
        if (reset) begin
            window_reg <= 3'd0;
            code_reg   <= 3'd0;
        end else if (clear) begin
            window_reg <= {2'b00, bit_in};
            code_reg   <= 3'd0;
        end else if (shift) begin
            window_reg <= window_next;
            code_reg   <= code_next;
        end
    end

    assign code = code_reg;

endmodule

// File: rtl/gfsk_tx_sequencer.sv
// -----------------------------------------------------------------------------
// gfsk_tx_sequencer
// Packet-level GFSK transmit controller: preamble, access address, len payload
// bytes (valid/ready stream through a one-entry buffer) and a zero tail, each
// field LSB first, one bit per SYMBOL_CYCLES clocks, shaped by gfsk_shaper.
//   clock, reset       : clock, synchronous active-high reset
//   start, len         : packet request (IDLE only) and payload byte count
//   in_data, in_valid  : payload byte stream
//   in_ready           : buffer empty and more bytes still needed
//   busy, done         : packet in progress / one-cycle end pulse
//   underrun           : sticky, a payload byte was missing at its boundary
//   bit_out, gfsk_out  : unshaped bit, shaped 3-bit frequency code
// -----------------------------------------------------------------------------
module gfsk_tx_sequencer
    import gfsk_pkg::*;
#(
    parameter int unsigned SYMBOL_CYCLES = 10,
    parameter logic [7:0]  PREAMBLE      = DEFAULT_PREAMBLE,
    parameter logic [31:0] ACCESS_ADDR   = DEFAULT_ACCESS_ADDR
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] len,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       busy,
    output logic       done,
    output logic       underrun,
    output logic       bit_out,
    output logic [2:0] gfsk_out
);

    localparam int SC_W = (SYMBOL_CYCLES > 1) ? $clog2(SYMBOL_CYCLES) : 1;

    logic [2:0]      state_reg, state_next;
    logic [SC_W-1:0] sym_cnt_reg;
    logic [4:0]      bit_idx_reg, bit_idx_next;
    logic [7:0]      byte_cnt_reg, byte_cnt_next;   // payload bytes loaded
    logic [7:0]      fetched_reg;                   // bytes taken from stream
    logic [7:0]      len_reg;
    logic [31:0]     shift_reg, shift_next;
    logic [7:0]      buf_data_reg;
    logic            buf_full_reg;
    logic            bit_out_reg;
    logic            done_reg;
    logic            underrun_reg;

    logic            sym_wrap, boundary, xfer, consume, finish;
    logic [7:0]      payload_byte;
    logic            shaper_clear, shaper_shift, shaper_bit;

    assign busy     = (state_reg != ST_IDLE);
    assign sym_wrap = (sym_cnt_reg == SC_W'(SYMBOL_CYCLES - 1));
    assign boundary = busy && sym_wrap;
    assign in_ready = !buf_full_reg
                      && ((state_reg == ST_ACCESS) || (state_reg == ST_PAYLOAD))
                      && (fetched_reg < len_reg);
    assign xfer     = in_valid && in_ready;

    // A missing byte is replaced by zeros; the caller flags underrun.
    assign payload_byte = buf_full_reg ? buf_data_reg : 8'h00;

    // Field sequencing evaluated for the next bit boundary
    always_comb begin
        state_next    = state_reg;
        bit_idx_next  = bit_idx_reg + 5'd1;
        shift_next    = {1'b0, shift_reg[31:1]};
        byte_cnt_next = byte_cnt_reg;
        consume       = 1'b0;
        finish        = 1'b0;
        case (state_reg)
            ST_PREAMBLE: begin
                if (bit_idx_reg == 5'd7) begin
                    state_next   = ST_ACCESS;
                    bit_idx_next = 5'd0;
                    shift_next   = ACCESS_ADDR;
                end
            end
            ST_ACCESS: begin
                if (bit_idx_reg == 5'd31) begin
                    bit_idx_next = 5'd0;
                    if (len_reg == 8'd0) begin
                        state_next = ST_TAIL;
                        shift_next = 32'd0;
                    end else begin
                        state_next    = ST_PAYLOAD;
                        shift_next    = {24'd0, payload_byte};
                        consume       = 1'b1;
                        byte_cnt_next = 8'd1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (bit_idx_reg == 5'd7) begin
                    bit_idx_next = 5'd0;
                    if (byte_cnt_reg == len_reg) begin
                        state_next = ST_TAIL;
                        shift_next = 32'd0;
                    end else begin
                        shift_next    = {24'd0, payload_byte};
                        consume       = 1'b1;
                        byte_cnt_next = byte_cnt_reg + 8'd1;
                    end
                end
            end
            ST_TAIL: begin
                if (bit_idx_reg == 5'(TAIL_BITS - 1)) begin
                    state_next   = ST_IDLE;
                    bit_idx_next = 5'd0;
                    shift_next   = 32'd0;
                    finish       = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            sym_cnt_reg  <= '0;
            bit_idx_reg  <= 5'd0;
            byte_cnt_reg <= 8'd0;
            fetched_reg  <= 8'd0;
            len_reg      <= 8'd0;
            shift_reg    <= 32'd0;
            buf_data_reg <= 8'd0;
            buf_full_reg <= 1'b0;
            bit_out_reg  <= 1'b0;
            done_reg     <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (xfer) begin
                buf_data_reg <= in_data;
                buf_full_reg <= 1'b1;
                fetched_reg  <= fetched_reg + 8'd1;
            end
            if (!busy) begin
                if (start) begin
                    state_reg    <= ST_PREAMBLE;
                    len_reg      <= len;
                    underrun_reg <= 1'b0;
                    buf_full_reg <= 1'b0;
                    fetched_reg  <= 8'd0;
                    byte_cnt_reg <= 8'd0;
                    bit_idx_reg  <= 5'd0;
                    sym_cnt_reg  <= '0;
                    shift_reg    <= {24'd0, PREAMBLE};
                    bit_out_reg  <= PREAMBLE[0];
                end
            end else begin
                sym_cnt_reg <= sym_wrap ? '0 : sym_cnt_reg + 1'b1;
                if (sym_wrap) begin
                    state_reg    <= state_next;
                    bit_idx_reg  <= bit_idx_next;
                    byte_cnt_reg <= byte_cnt_next;
                    shift_reg    <= shift_next;
                    bit_out_reg  <= shift_next[0];
                    done_reg     <= finish;
                    // xfer cannot coincide with a full buffer, so clearing
                    // here never drops a freshly written byte.
                    if (consume) begin
                        if (buf_full_reg) begin
                            buf_full_reg <= 1'b0;
                        end else begin
                            underrun_reg <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Start seeds the window with preamble bit 0; returning to IDLE seeds it
    // with zero so gfsk_out settles to 0.
    assign shaper_clear = (!busy && start) || (boundary && finish);
    assign shaper_shift = boundary && !finish;
    assign shaper_bit   = busy ? shift_next[0] : PREAMBLE[0];

    gfsk_shaper u_shaper (
        .clock  (clock),
        .reset  (reset),
        .clear  (shaper_clear),
        .shift  (shaper_shift),
        .bit_in (shaper_bit),
        .code   (gfsk_out)
    );

    assign done     = done_reg;
    assign underrun = underrun_reg;
    assign bit_out  = bit_out_reg;

endmodule

// File: tb/tb_gfsk_tx_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gfsk_tx_sequencer
// Scoreboard bench: each packet's expected bit/code stream is built from the
// field layout and the 2-3-2 shaping formula and queued at start; entries are
// popped mid-symbol and compared with bit_out / gfsk_out.
// -----------------------------------------------------------------------------
module tb_gfsk_tx_sequencer;

    localparam int SC0 = 10;
    localparam logic [7:0]  PRE = 8'hAA;
    localparam logic [31:0] AA  = 32'h8E89BED6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start, in_valid, in_ready, busy, done, underrun, bit_out;
    logic [7:0] len, in_data;
    logic [2:0] gfsk_out;
    logic       start_f, in_valid_f, in_ready_f, busy_f, done_f, underrun_f, bit_out_f;
    logic [7:0] len_f, in_data_f;
    logic [2:0] gfsk_out_f;

    gfsk_tx_sequencer #(.SYMBOL_CYCLES(SC0)) dut (
        .clock(clk), .reset(reset), .start(start), .len(len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .busy(busy), .done(done), .underrun(underrun),
        .bit_out(bit_out), .gfsk_out(gfsk_out)
    );

    gfsk_tx_sequencer #(.SYMBOL_CYCLES(1)) dut_fast (
        .clock(clk), .reset(reset), .start(start_f), .len(len_f),
        .in_data(in_data_f), .in_valid(in_valid_f), .in_ready(in_ready_f),
        .busy(busy_f), .done(done_f), .underrun(underrun_f),
        .bit_out(bit_out_f), .gfsk_out(gfsk_out_f)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] pay[$];
    logic       exp_bits[$];
    logic [2:0] exp_codes[$];
    logic [2:0] obs_codes[$];

    // Reference stream: preamble, access address, payload (zeros if not fed),
    // two tail zeros; code in symbol j is 2*b[j-2] + 3*b[j-1] + 2*b[j].
    function automatic void build_expected(input int n, input bit feed);
        logic       b[$];
        logic [7:0] pre_v, v;
        logic [31:0] aa_v;
        int p, cu, nx;
        pre_v = PRE;
        aa_v  = AA;
        for (int i = 0; i < 8; i++)  b.push_back(pre_v[i]);
        for (int i = 0; i < 32; i++) b.push_back(aa_v[i]);
        for (int k = 0; k < n; k++) begin
            v = feed ? pay[k] : 8'h00;
            for (int i = 0; i < 8; i++) b.push_back(v[i]);
        end
        b.push_back(1'b0);
        b.push_back(1'b0);
        exp_bits.delete();
        exp_codes.delete();
        for (int j = 0; j < b.size(); j++) begin
            p  = (j >= 2) ? int'(b[j-2]) : 0;
            cu = (j >= 1) ? int'(b[j-1]) : 0;
            nx = int'(b[j]);
            exp_bits.push_back(b[j]);
            exp_codes.push_back((j == 0) ? 3'd0 : 3'(2*p + 3*cu + 2*nx));
        end
    endfunction

    // One packet on the SYMBOL_CYCLES=10 instance. midstart_at < 0 disables
    // the ignored-start pulse.
    task automatic run_packet(input int n, input bit feed, input bit exp_underrun,
                              input int midstart_at);
        int c, busy_cycles, xfers, idx, limit;
        bit fin, done_early;
        logic eb;
        logic [2:0] ec;
        build_expected(n, feed);
        obs_codes.delete();
        limit = (42 + 8*n)*SC0 + 50;
        @(negedge clk);
        start = 1'b1; len = 8'(n); in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        c = 1; busy_cycles = 0; xfers = 0; idx = 0; fin = 1'b0; done_early = 1'b0;
        while (!fin && c < limit) begin
            if (c == 1) begin
                vectors++;
                if (underrun !== 1'b0) begin
                    miscompares++;
                    $display("FAIL underrun_clear_on_start: got %b want 0", underrun);
                end
            end
            if (busy === 1'b1) begin
                busy_cycles++;
                if (done !== 1'b0) done_early = 1'b1;
                if (((c - 1) % SC0) == SC0/2) begin
                    vectors++;
                    if (exp_bits.size() == 0) begin
                        miscompares++;
                        $display("FAIL sym_queue: got extra symbol at cycle %0d want none", c);
                    end else begin
                        eb = exp_bits.pop_front();
                        ec = exp_codes.pop_front();
                        obs_codes.push_back(gfsk_out);
                        if (bit_out !== eb || gfsk_out !== ec) begin
                            miscompares++;
                            $display("FAIL symbol_c%0d: got bit=%b code=%0d want bit=%b code=%0d",
                                     c, bit_out, gfsk_out, eb, ec);
                        end
                    end
                end
            end else begin
                fin = 1'b1;
                vectors++;
                if (done !== 1'b1 || bit_out !== 1'b0 || gfsk_out !== 3'd0) begin
                    miscompares++;
                    $display("FAIL end_cycle: got done=%b bit=%b code=%0d want done=1 bit=0 code=0",
                             done, bit_out, gfsk_out);
                end
            end
            if (c == 40*SC0) begin
                vectors++;
                if (underrun !== 1'b0) begin
                    miscompares++;
                    $display("FAIL underrun_pre_payload: got %b want 0", underrun);
                end
            end
            if (n > 0 && c == 48*SC0 + 2) begin
                vectors++;
                if (underrun !== exp_underrun) begin
                    miscompares++;
                    $display("FAIL underrun_first_byte: got %b want %b", underrun, exp_underrun);
                end
            end
            // Drive stream for the next edge, then note whether it transfers
            in_valid = feed && (idx < n);
            in_data  = (idx < n) ? pay[idx] : 8'h00;
            if (in_valid && in_ready) begin
                xfers++;
                idx++;
            end
            if (c == midstart_at) begin
                start = 1'b1;
                len   = 8'(n + 3);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        vectors++;
        if (!fin) begin
            miscompares++;
            $display("FAIL packet_timeout: got busy after %0d cycles want idle", c);
        end
        vectors++;
        if (busy_cycles != (42 + 8*n)*SC0) begin
            miscompares++;
            $display("FAIL busy_cycles: got %0d want %0d", busy_cycles, (42 + 8*n)*SC0);
        end
        vectors++;
        if (exp_bits.size() != 0 || done_early) begin
            miscompares++;
            $display("FAIL sym_drain: got %0d unsent, early_done=%b want 0,0", exp_bits.size(), done_early);
        end
        vectors++;
        if (underrun !== exp_underrun) begin
            miscompares++;
            $display("FAIL underrun_final: got %b want %b", underrun, exp_underrun);
        end
        if (feed) begin
            vectors++;
            if (xfers != n) begin
                miscompares++;
                $display("FAIL transfers: got %0d want %0d", xfers, n);
            end
        end
        // done is a single-cycle pulse
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_width: got %b want 0 one cycle later", done);
        end
        $display("packet len=%0d feed=%0b busy_cycles=%0d xfers=%0d underrun=%b",
                 n, feed, busy_cycles, xfers, underrun);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, done, underrun, bit_out, gfsk_out, in_ready} !== 8'd0 ||
            {busy_f, done_f, gfsk_out_f} !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_state: got busy=%b done=%b ur=%b bit=%b code=%0d rdy=%b want all 0",
                     busy, done, underrun, bit_out, gfsk_out, in_ready);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_len0();
        logic [2:0] want [6] = '{3'd2, 3'd3, 3'd4, 3'd3, 3'd4, 3'd3};
        pay.delete();
        run_packet(0, 1'b0, 1'b0, -1);
        vectors++;
        if (obs_codes.size() < 7) begin
            miscompares++;
            $display("FAIL len0_code_count: got %0d want >=7", obs_codes.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                vectors++;
                if (obs_codes[i+1] !== want[i]) begin
                    miscompares++;
                    $display("FAIL len0_code%0d: got %0d want %0d", i + 1, obs_codes[i+1], want[i]);
                end
            end
        end
    endtask

    task automatic test_payload_fed();
        pay = '{8'h01, 8'hFF};
        run_packet(2, 1'b1, 1'b0, -1);
    endtask

    task automatic test_underrun();
        pay = '{8'h01, 8'hFF};
        run_packet(2, 1'b0, 1'b1, -1);
    endtask

    task automatic test_start_ignored();
        pay = '{8'h5A, 8'hC3};
        run_packet(2, 1'b1, 1'b0, 1 + 44*SC0);
    endtask

    task automatic test_reset_abort();
        bit saw;
        @(negedge clk);
        start = 1'b1; len = 8'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (20*SC0) @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_precondition: got busy=%b want 1", busy);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if ({busy, done, underrun, bit_out, gfsk_out, in_ready} !== 8'd0) begin
            miscompares++;
            $display("FAIL abort_outputs: got busy=%b done=%b bit=%b code=%0d rdy=%b want all 0",
                     busy, done, bit_out, gfsk_out, in_ready);
        end
        saw = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) saw = 1'b1;
        end
        vectors++;
        if (saw) begin
            miscompares++;
            $display("FAIL abort_no_done: got done/busy activity want none");
        end
        pay = '{8'h3C};
        run_packet(1, 1'b1, 1'b0, -1);
    endtask

    task automatic test_fast_symbol();
        int c, busy_cycles, idx;
        bit fin;
        logic eb;
        logic [2:0] ec;
        pay = '{8'hA5};
        build_expected(1, 1'b1);
        @(negedge clk);
        start_f = 1'b1; len_f = 8'd1;
        @(negedge clk);
        start_f = 1'b0;
        c = 1; busy_cycles = 0; idx = 0; fin = 1'b0;
        while (!fin && c < 200) begin
            if (busy_f === 1'b1) begin
                busy_cycles++;
                vectors++;
                if (exp_bits.size() == 0) begin
                    miscompares++;
                    $display("FAIL fast_queue: got extra symbol at cycle %0d want none", c);
                end else begin
                    eb = exp_bits.pop_front();
                    ec = exp_codes.pop_front();
                    if (bit_out_f !== eb || gfsk_out_f !== ec) begin
                        miscompares++;
                        $display("FAIL fast_c%0d: got bit=%b code=%0d want bit=%b code=%0d",
                                 c, bit_out_f, gfsk_out_f, eb, ec);
                    end
                end
            end else begin
                fin = 1'b1;
                vectors++;
                if (done_f !== 1'b1 || underrun_f !== 1'b0) begin
                    miscompares++;
                    $display("FAIL fast_end: got done=%b ur=%b want done=1 ur=0", done_f, underrun_f);
                end
            end
            in_valid_f = (idx < 1);
            in_data_f  = pay[0];
            if (in_valid_f && in_ready_f) idx++;
            @(negedge clk);
            c++;
        end
        in_valid_f = 1'b0;
        vectors++;
        if (!fin || busy_cycles != 50) begin
            miscompares++;
            $display("FAIL fast_busy_cycles: got %0d (fin=%b) want 50", busy_cycles, fin);
        end
        $display("packet fast len=1 busy_cycles=%0d", busy_cycles);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0; len = 8'd0; in_data = 8'd0; in_valid = 1'b0;
        start_f = 1'b0; len_f = 8'd0; in_data_f = 8'd0; in_valid_f = 1'b0;
        test_reset();
        test_len0();
        test_payload_fed();
        test_underrun();
        test_start_ignored();
        test_reset_abort();
        test_fast_symbol();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
